ula_ctrl_md: RTL and testbench

- Next-generation ALU control unit. Decodes ALUOp/funct to ALUControl as today, and adds funct-decoded multiply/divide ops with an iterative WIDTH-parametrised multiply/divide engine, HI/LO registers and a stall handshake to the pipeline.
- Sits between the main control/ID stage and the EX-stage ULA.

---
 rtl/ula_pkg.sv | 73 +++++++
 rtl/ula_md_iter.sv | 83 ++++++++
 rtl/ula_ctrl_md.sv | 175 +++++++++++++++++
 tb/tb_ula_ctrl_md.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ula_pkg
// Description : Shared codes, FSM state type and MD-op helper for ula_ctrl_md.
// Revision    : 1.0 - initial release
// ============================================================================
package ula_pkg;

    // ULA operation codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLLV = 4'b0011;
    localparam logic [3:0] ALU_SRLV = 4'b0100;
    localparam logic [3:0] ALU_SRAV = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_LUI  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_XOR  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    // ALUOp classes from main control
    localparam logic [3:0] AOP_RTYPE = 4'b0000;
    localparam logic [3:0] AOP_SUB   = 4'b0100;
    localparam logic [3:0] AOP_LUI   = 4'b0101;
    localparam logic [3:0] AOP_ADDI  = 4'b1000;
    localparam logic [3:0] AOP_SLTI  = 4'b1010;
    localparam logic [3:0] AOP_SLTIU = 4'b1011;
    localparam logic [3:0] AOP_ANDI  = 4'b1100;
    localparam logic [3:0] AOP_ORI   = 4'b1101;
    localparam logic [3:0] AOP_XORI  = 4'b1110;

    // R-type funct codes
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_t;

    function automatic logic is_md(input logic [5:0] fn);
        return (fn == F_MULT) || (fn == F_MULTU) || (fn == F_DIV) || (fn == F_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ula_md_iter.sv
`default_nettype none
// ============================================================================
// Module      : ula_md_iter
// Description : One-bit-per-cycle unsigned shift-add multiply / restoring divide.
// Revision    : 1.0 - initial release
// ============================================================================
module ula_md_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_step,
    input  logic             i_clear,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_acc_nx;
    logic [WIDTH-1:0] w_q_nx;

    // Multiply: {acc,q} shifts right with the carry; divide: {acc,q} shifts left
    always_comb begin
        w_sum    = {1'b0, r_acc} + {1'b0, r_m};
        w_shl    = {r_acc, r_q[WIDTH-1]};
        w_diff   = w_shl - {1'b0, r_m};
        w_acc_nx = r_acc;
        w_q_nx   = r_q;
        if (i_div) begin
            if (!w_diff[WIDTH]) begin
                w_acc_nx = w_diff[WIDTH-1:0];
                w_q_nx   = {r_q[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nx = w_shl[WIDTH-1:0];
                w_q_nx   = {r_q[WIDTH-2:0], 1'b0};
            end
        end else if (r_q[0]) begin
            w_acc_nx = w_sum[WIDTH:1];
            w_q_nx   = {w_sum[0], r_q[WIDTH-1:1]};
        end else begin
            w_acc_nx = {1'b0, r_acc[WIDTH-1:1]};
            w_q_nx   = {r_acc[0], r_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_acc <= '0;
            r_q   <= i_div ? i_a : i_b;
            r_m   <= i_div ? i_b : i_a;
            r_cnt <= CNT_W'(WIDTH);
        end else if (i_step) begin
            r_acc <= w_acc_nx;
            r_q   <= w_q_nx;
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_hi    = r_acc;
    assign o_lo    = r_q;
    assign o_count = r_cnt;

endmodule
`default_nettype wire

// File: rtl/ula_ctrl_md.sv
`default_nettype none
// ============================================================================
// Module      : ula_ctrl_md
// Description : ALU control decode plus iterative MD engine, HI/LO and stall.
// Revision    : 1.0 - initial release
// ============================================================================
module ula_ctrl_md #(
    parameter int WIDTH   = 32,
    parameter int ALUOP_W = 4,
    parameter int FUNCT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_i,
    input  logic               flush_i,
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [3:0]         ALUControl,
    output logic               illegal_o,
    output logic               md_busy_o,
    output logic               stall_o,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o,
    output logic [WIDTH-1:0]   mf_data_o
);
    import ula_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 1);

    md_state_t          r_state, w_state_nx;
    logic [5:0]         w_fn;
    logic [3:0]         w_aop;
    logic               w_rtype, w_md, w_div_op, w_signed, w_mf, w_mt;
    logic               w_accept, w_a_neg, w_b_neg, w_step, w_div_mode, w_idle;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_acc, w_q, w_quo, w_rem;
    logic [2*WIDTH-1:0] w_prod;
    logic [CNT_W-1:0]   w_count;
    logic               r_sgn_q, r_sgn_r, r_div0, r_is_div;
    logic [WIDTH-1:0]   r_hi, r_lo;

    assign w_fn  = 6'(funct);
    assign w_aop = 4'(ALUOp);

    always_comb begin
        ALUControl = ALU_ADD;
        illegal_o  = 1'b0;
        case (w_aop)
            AOP_RTYPE: begin
                case (w_fn)
                    F_SLL:  ALUControl = ALU_SLL;
                    F_SRL:  ALUControl = ALU_SRL;
                    F_SRA:  ALUControl = ALU_SRA;
                    F_SLLV: ALUControl = ALU_SLLV;
                    F_SRLV: ALUControl = ALU_SRLV;
                    F_SRAV: ALUControl = ALU_SRAV;
                    F_ADD:  ALUControl = ALU_ADD;
                    F_SUB:  ALUControl = ALU_SUB;
                    F_AND:  ALUControl = ALU_AND;
                    F_OR:   ALUControl = ALU_OR;
                    F_XOR:  ALUControl = ALU_XOR;
                    F_NOR:  ALUControl = ALU_NOR;
                    F_SLT:  ALUControl = ALU_SLT;
                    F_SLTU: ALUControl = ALU_SLTU;
                    F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                    F_MULT, F_MULTU, F_DIV, F_DIVU: ALUControl = ALU_ADD;
                    default: begin
                        ALUControl = ALU_AND;
                        illegal_o  = 1'b1;
                    end
                endcase
            end
            AOP_SUB:   ALUControl = ALU_SUB;
            AOP_LUI:   ALUControl = ALU_LUI;
            AOP_ADDI:  ALUControl = ALU_ADD;
            AOP_SLTI:  ALUControl = ALU_SLT;
            AOP_SLTIU: ALUControl = ALU_SLTU;
            AOP_ANDI:  ALUControl = ALU_AND;
            AOP_ORI:   ALUControl = ALU_OR;
            AOP_XORI:  ALUControl = ALU_XOR;
            default:   ALUControl = ALU_ADD;
        endcase
    end

    assign w_rtype  = (w_aop == AOP_RTYPE);
    assign w_md     = w_rtype & is_md(w_fn);
    assign w_div_op = (w_fn == F_DIV) | (w_fn == F_DIVU);
    assign w_signed = (w_fn == F_MULT) | (w_fn == F_DIV);
    assign w_mf     = w_rtype & ((w_fn == F_MFHI) | (w_fn == F_MFLO));
    assign w_mt     = w_rtype & ((w_fn == F_MTHI) | (w_fn == F_MTLO));
    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle & valid_i & w_md & !flush_i;
    assign stall_o  = valid_i & (w_md | w_mf | w_mt) & !w_idle & !flush_i;
    assign md_busy_o = !w_idle;

    assign w_a_neg    = w_signed & op_a[WIDTH-1];
    assign w_b_neg    = w_signed & op_b[WIDTH-1];
    assign w_mag_a    = w_a_neg ? -op_a : op_a;
    assign w_mag_b    = w_b_neg ? -op_b : op_b;
    assign w_step     = (r_state == MUL) | (r_state == DIV);
    assign w_div_mode = w_idle ? w_div_op : (r_state == DIV);

    ula_md_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_accept),
        .i_step  (w_step),
        .i_clear (flush_i),
        .i_div   (w_div_mode),
        .i_a     (w_mag_a),
        .i_b     (w_mag_b),
        .o_hi    (w_acc),
        .o_lo    (w_q),
        .o_count (w_count)
    );

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_state_nx = w_div_op ? DIV : MUL;
            MUL, DIV: if (w_count == CNT_W'(1)) w_state_nx = FIX;
            FIX:      w_state_nx = IDLE;
            default:  w_state_nx = IDLE;
        endcase
        if (flush_i) w_state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    // Divide-by-zero leaves the remainder path holding |op_a|, so only LO needs overriding
    assign w_prod = r_sgn_q ? -{w_acc, w_q} : {w_acc, w_q};
    assign w_quo  = r_div0 ? '1 : (r_sgn_q ? -w_q : w_q);
    assign w_rem  = r_sgn_r ? -w_acc : w_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sgn_q  <= 1'b0;
            r_sgn_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_is_div <= 1'b0;
        end else if (w_accept) begin
            r_sgn_q  <= w_a_neg ^ w_b_neg;
            r_sgn_r  <= w_a_neg;
            r_div0   <= w_div_op & (op_b == '0);
            r_is_div <= w_div_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if ((r_state == FIX) && !flush_i) begin
            r_hi <= r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
            r_lo <= r_is_div ? w_quo : w_prod[WIDTH-1:0];
        end else if (w_idle && valid_i && !flush_i && w_mt) begin
            if (w_fn == F_MTHI) r_hi <= op_a;
            else                r_lo <= op_a;
        end
    end

    assign hi_o      = r_hi;
    assign lo_o      = r_lo;
    assign mf_data_o = (w_rtype && (w_fn == F_MFHI)) ? r_hi :
                       (w_rtype && (w_fn == F_MFLO)) ? r_lo : '0;

endmodule
`default_nettype wire

// File: tb/tb_ula_ctrl_md.sv
`default_nettype none
// ============================================================================
// Module      : tb_ula_ctrl_md
// Description : Directed self-checking bench for ula_ctrl_md (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ula_ctrl_md;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_i;
    logic         flush_i;
    logic [3:0]   ALUOp;
    logic [5:0]   funct;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [3:0]   ALUControl;
    logic         illegal_o;
    logic         md_busy_o;
    logic         stall_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;
    logic [W-1:0] mf_data_o;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010, MTLO = 6'b010011;
    localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;
    localparam logic [5:0] ADD  = 6'b100000;

    ula_ctrl_md #(.WIDTH(W), .ALUOP_W(4), .FUNCT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid_i),
        .flush_i    (flush_i),
        .ALUOp      (ALUOp),
        .funct      (funct),
        .op_a       (op_a),
        .op_b       (op_b),
        .ALUControl (ALUControl),
        .illegal_o  (illegal_o),
        .md_busy_o  (md_busy_o),
        .stall_o    (stall_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .mf_data_o  (mf_data_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected {illegal, ALUControl} from the decode table
    function automatic logic [4:0] exp_dec(input int aop, input int fn);
        logic [4:0] r;
        r = 5'b0_0010;
        if (aop != 0) begin
            case (aop)
                4:  r = 5'b0_0110;
                5:  r = 5'b0_1000;
                8:  r = 5'b0_0010;
                10: r = 5'b0_0111;
                11: r = 5'b0_1111;
                12: r = 5'b0_0000;
                13: r = 5'b0_0001;
                14: r = 5'b0_1011;
                default: r = 5'b0_0010;
            endcase
        end else begin
            case (fn)
                0:  r = 5'b0_1001;
                2:  r = 5'b0_1010;
                3:  r = 5'b0_1101;
                4:  r = 5'b0_0011;
                6:  r = 5'b0_0100;
                7:  r = 5'b0_0101;
                16, 17, 18, 19, 24, 25, 26, 27, 32: r = 5'b0_0010;
                34: r = 5'b0_0110;
                36: r = 5'b0_0000;
                37: r = 5'b0_0001;
                38: r = 5'b0_1011;
                39: r = 5'b0_1100;
                42: r = 5'b0_0111;
                43: r = 5'b0_1111;
                default: r = 5'b1_0000;
            endcase
        end
        return r;
    endfunction

    task automatic present(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        valid_i = 1'b1;
        ALUOp   = 4'b0000;
        funct   = f;
        op_a    = a;
        op_b    = b;
    endtask

    // Issue one MD op, drop valid after the accept edge, count busy samples
    task automatic run_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int busy);
        @(negedge clk);
        present(f, a, b);
        @(posedge clk); #1;
        valid_i = 1'b0;
        busy = 0;
        while (md_busy_o && busy < 100) begin
            busy++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int busy;
        int bad;

        rst_n   = 1'b0;
        flush_i = 1'b0;
        present(MULT, 32'd3, 32'd5);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hi", hi_o, 0);
        chk("reset_lo", lo_o, 0);
        chk("reset_busy", md_busy_o, 0);
        chk("reset_stall", stall_o, 0);
        @(negedge clk);
        valid_i = 1'b0;
        rst_n   = 1'b1;

        for (int a = 0; a < 16; a++) begin
            for (int f = 0; f < 64; f++) begin
                ALUOp = a[3:0];
                funct = f[5:0];
                #1;
                chk($sformatf("decode aop=%0d fn=%0d", a, f), {59'd0, illegal_o, ALUControl}, {59'd0, exp_dec(a, f)});
            end
        end

        run_md(MULT, 32'd3, 32'hFFFF_FFFB, busy);
        chk("mult_busy_cycles", busy, 33);
        chk("mult_hi", hi_o, 32'hFFFF_FFFF);
        chk("mult_lo", lo_o, 32'hFFFF_FFF1);

        run_md(MULTU, 32'd3, 32'hFFFF_FFFB, busy);
        chk("multu_hi", hi_o, 32'h0000_0002);
        chk("multu_lo", lo_o, 32'hFFFF_FFF1);

        run_md(DIVU, 32'd100, 32'd7, busy);
        chk("divu_lo", lo_o, 32'd14);
        chk("divu_hi", hi_o, 32'd2);

        run_md(DIV, 32'hFFFF_FFF9, 32'd2, busy);
        chk("div_neg_lo", lo_o, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi_o, 32'hFFFF_FFFF);

        run_md(DIV, 32'h8000_0000, 32'hFFFF_FFFF, busy);
        chk("div_min_lo", lo_o, 32'h8000_0000);
        chk("div_min_hi", hi_o, 32'h0000_0000);

        run_md(DIV, 32'h0000_1234, 32'd0, busy);
        chk("div0_busy_cycles", busy, 33);
        chk("div0_lo", lo_o, 32'hFFFF_FFFF);
        chk("div0_hi", hi_o, 32'h0000_1234);

        // MULT 6*7, then ADD (no stall) and MFLO (stall until idle)
        @(negedge clk);
        present(MULT, 32'd6, 32'd7);
        @(posedge clk); #1;
        present(ADD, 32'd1, 32'd2);
        #1;
        chk("add_no_stall", stall_o, 0);
        chk("add_ctrl_busy", ALUControl, 4'b0010);
        present(MFLO, 32'd0, 32'd0);
        #1;
        chk("mflo_stall", stall_o, 1);
        bad  = 0;
        busy = 0;
        while (md_busy_o && busy < 100) begin
            if (stall_o !== 1'b1) bad++;
            busy++;
            @(posedge clk); #1;
        end
        chk("mflo_stall_whole_window", bad, 0);
        chk("mflo_window_cycles", busy, 33);
        chk("mflo_stall_released", stall_o, 0);
        chk("mflo_data", mf_data_o, 32'd42);
        funct = MFHI;
        #1;
        chk("mfhi_data", mf_data_o, 32'd0);
        valid_i = 1'b0;

        // MTHI / MTLO
        @(negedge clk);
        present(MTHI, 32'h55, 32'd0);
        @(posedge clk); #1;
        chk("mthi", hi_o, 32'h55);
        @(negedge clk);
        present(MTLO, 32'hAA, 32'd0);
        @(posedge clk); #1;
        valid_i = 1'b0;
        chk("mtlo", lo_o, 32'hAA);

        // Flush during iteration 10
        @(negedge clk);
        present(DIVU, 32'd100, 32'd7);
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush_busy", md_busy_o, 0);
        chk("flush_hi", hi_o, 32'h55);
        chk("flush_lo", lo_o, 32'hAA);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_hi_late", hi_o, 32'h55);
        chk("flush_lo_late", lo_o, 32'hAA);

        // Asynchronous reset mid-DIV
        @(negedge clk);
        present(DIV, 32'd100, 32'd7);
        @(posedge clk); #1;
        present(MFLO, 32'd0, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("pre_reset_stall", stall_o, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", md_busy_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        valid_i = 1'b0;

        run_md(DIVU, 32'd100, 32'd7, busy);
        chk("post_reset_divu_lo", lo_o, 32'd14);
        chk("post_reset_divu_hi", hi_o, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
